red_pitaya_dac_slew: RTL and testbench
======================================

Name: red_pitaya_dac_slew

Overview:
- Output-conditioning stage directly downstream of the DSP summing/saturation stage; one instance per DAC channel.
- Takes the saturated 14-bit DAC word and limits its rate of change: max `step_i` LSB per update tick, ticks every `prescale_i+1` clocks.
- Protects piezo/laser-current actuators from step commands.
- Bypass mode passes data through with one register stage.

Parameters:
- DW, 14, data width of the signed two's-complement DAC word
- PW, 16, prescaler counter width

Ports:
- clk_i  in  1  processing clock
- rst_i  in  1  synchronous reset, active high
- dat_i  in  DW  signed target word from DSP sum/saturate stage
- enable_i  in  1  1 = slew limiting active, 0 = bypass
- hold_i  in  1  freeze output and prescaler while high
- step_i  in  DW  unsigned max change per tick (LSB)
- prescale_i  in  PW  tick period minus one (0 = tick every clock)
- dat_o  out  DW  signed slew-limited output to DAC
- settled_o  out  1  dat_o equals dat_i (registered)
- slewing_o  out  1  FSM in SLEW state
- limited_o  out  1  sticky: set on any tick where limiting clipped the change; cleared by reset or by enable_i low

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high. All state updates on posedge clk_i.
- Reset values: dat_o=0, cnt=0, state=BYPASS, settled_o=0, slewing_o=0, limited_o=0.
- Prescaler:
  - cnt counts 0..prescale_i; tick=1 when cnt>=prescale_i, then cnt<=0.
  - The ">=" covers prescale_i lowered below cnt.
  - hold_i=1: cnt frozen, tick suppressed.
  - cnt is forced to 0 in BYPASS.
- Difference: diff = sext(dat_i) - sext(dat_o), DW+1 bits signed, no overflow possible. Compare |diff| (DW bits unsigned) with step_i.
- FSM states:
  - BYPASS:
    - dat_o<=dat_i each cycle (latency 1).
    - enable_i=1 -> TRACK; dat_o holds its current value, no jump on entry.
  - TRACK (settled):
    - On tick with |diff|<=step_i: dat_o<=dat_i.
    - On tick with |diff|>step_i: dat_o<=dat_o±step_i (sign of diff), limited_o<=1, -> SLEW.
  - SLEW:
    - On each tick, the same update rule.
    - Leaves to TRACK on the tick where |diff|<=step_i (final dat_o<=dat_i).
  - Any state, enable_i=0: -> BYPASS next cycle, dat_o<=dat_i, limited_o<=0, cnt<=0.
- step_i=0 while enabled: dat_o never changes. FSM enters/stays SLEW if diff≠0. limited_o is set on ticks with diff≠0.
- Overshoot impossible: when |diff|>step_i, dat_o±step_i lies strictly between dat_o and dat_i, so no wrap-around. No saturation logic needed.
- hold_i has priority over tick. enable_i=0 has priority over hold_i.
- settled_o <= (next dat_o == dat_i) each cycle; in BYPASS it is 1 whenever dat_i is constant for 2 cycles.
- slewing_o is registered; it equals state==SLEW.
- Reset mid-slew: all state returns to reset values on the next edge; dat_o=0 regardless of dat_i.

Optional Feature:
- Macro DAC_SLEW_CLAMP_EN.
- Defined:
  - Adds ports lo_i, hi_i (in, DW, signed).
  - The target is clamp(dat_i, lo_i, hi_i), applied before diff and in BYPASS. Latency unchanged (same register stage).
  - lo_i>hi_i: target=lo_i.
  - settled_o compares against the clamped target.
- Undefined: ports absent; target=dat_i.

Decomposition:
- Shared package/header red_pitaya_dsp_pkg:
  - FSM state encodings: BYPASS=2'd0, TRACK=2'd1, SLEW=2'd2.
  - Default DW=14.
- One sub-module: red_pitaya_tick_gen (prescaler counter with hold and clear inputs, tick output), reusable by other rate-divided DSP blocks.

Test Plan:
- Reset, then enable_i=0, dat_i=100 then 5000 -> dat_o=100 one cycle after dat_i=100, dat_o=5000 one cycle after change; settled_o=1 next cycle; limited_o=0.
- enable_i=1, prescale_i=0, step_i=1000, dat_o=0, dat_i steps to 3500 -> dat_o 1000, 2000, 3000, 3500 on four consecutive cycles; slewing_o high for the first three; limited_o=1 and sticky; settled_o=1 after 3500.
- prescale_i=3, step_i=10, dat_o=0, dat_i=-25 -> dat_o=-10 at 4th clock, -20 at 8th, -25 at 12th; no change between ticks.
- Mid-slew hold_i=1 for 20 cycles -> dat_o and cnt frozen; after release, slewing resumes with the same tick phase. Mid-slew enable_i=0 -> dat_o=dat_i next cycle, state BYPASS, limited_o=0.
- Extremes: dat_o=-8192, dat_i=8191, step_i=16383 -> single tick to 8191, no wrap. Then step_i=0, dat_i=0 -> dat_o stays 8191 indefinitely, slewing_o=1.
- With DAC_SLEW_CLAMP_EN: lo_i=-100, hi_i=200, bypass, dat_i=1000 -> dat_o=200; dat_i=-500 -> dat_o=-100. Assert rst_i mid-slew -> dat_o=0 next edge.

Source files
------------

// File: rtl/red_pitaya_dsp_pkg.sv
// Shared definitions for the rate-divided DSP output stages.
// Holds the slew FSM state encoding and the default DAC word width.
package red_pitaya_dsp_pkg;

    localparam int DSP_DW = 14;

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SLEW   = 2'd2
    } dsp_state_e;

endpackage

// File: rtl/red_pitaya_tick_gen.sv
// Prescaler: tick_o pulses combinationally when cnt reaches prescale_i (one tick every prescale_i+1 clocks).
// hold_i freezes the count and masks the tick; clr_i forces the count to zero and wins over hold_i.
module red_pitaya_tick_gen #(
    parameter int PW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          hold_i,
    input  logic [PW-1:0] prescale_i,
    output logic          tick_o
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick;

    // ">=" so that lowering prescale_i below the current count still ticks
    assign tick   = !clr_i && !hold_i && (cnt_q >= prescale_i);
    assign tick_o = tick;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hold_i) begin
            cnt_d = cnt_q;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/red_pitaya_dac_slew.sv
// DAC slew-rate limiter: at most step_i LSB of change per prescaled tick; bypass passes data with 1-cycle latency.
// Optional DAC_SLEW_CLAMP_EN adds lo_i/hi_i and clamps the target before slewing and in bypass.
module red_pitaya_dac_slew
    import red_pitaya_dsp_pkg::*;
#(
    parameter int DW = DSP_DW,
    parameter int PW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [DW-1:0] dat_i,
    input  logic                 enable_i,
    input  logic                 hold_i,
    input  logic        [DW-1:0] step_i,
    input  logic        [PW-1:0] prescale_i,
`ifdef DAC_SLEW_CLAMP_EN
    input  logic signed [DW-1:0] lo_i,
    input  logic signed [DW-1:0] hi_i,
`endif
    output logic signed [DW-1:0] dat_o,
    output logic                 settled_o,
    output logic                 slewing_o,
    output logic                 limited_o
);

    dsp_state_e          state_q, state_d;
    logic signed [DW-1:0] dat_q, dat_d;
    logic signed [DW-1:0] tgt;
    logic signed [DW:0]   diff;
    logic        [DW-1:0] abs_diff;
    logic                 settled_q, settled_d;
    logic                 slewing_q, slewing_d;
    logic                 limited_q, limited_d;
    logic                 tick;
    logic                 cnt_clr;

`ifdef DAC_SLEW_CLAMP_EN
    // An inverted window collapses to lo_i
    always_comb begin
        if (lo_i > hi_i) begin
            tgt = lo_i;
        end else if (dat_i < lo_i) begin
            tgt = lo_i;
        end else if (dat_i > hi_i) begin
            tgt = hi_i;
        end else begin
            tgt = dat_i;
        end
    end
`else
    assign tgt = dat_i;
`endif

    // One extra bit makes the difference exact for any pair of DW-bit words
    assign diff     = {tgt[DW-1], tgt} - {dat_q[DW-1], dat_q};
    assign abs_diff = diff[DW] ? DW'(-diff) : DW'(diff);

    assign cnt_clr = !enable_i || (state_q == ST_BYPASS);

    red_pitaya_tick_gen #(
        .PW(PW)
    ) u_tick_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cnt_clr),
        .hold_i     (hold_i),
        .prescale_i (prescale_i),
        .tick_o     (tick)
    );

    always_comb begin
        state_d   = state_q;
        dat_d     = dat_q;
        limited_d = limited_q;
        if (!enable_i) begin
            state_d   = ST_BYPASS;
            dat_d     = tgt;
            limited_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_BYPASS: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK, ST_SLEW: begin
                    if (tick) begin
                        if (abs_diff <= step_i) begin
                            dat_d   = tgt;
                            state_d = ST_TRACK;
                        end else begin
                            // |diff| > step_i keeps the stepped value strictly inside the range, so modular add is exact
                            dat_d     = diff[DW] ? dat_q - step_i : dat_q + step_i;
                            limited_d = 1'b1;
                            state_d   = ST_SLEW;
                        end
                    end
                end
                default: begin
                    state_d = ST_BYPASS;
                    dat_d   = tgt;
                end
            endcase
        end
        settled_d = (dat_d == tgt);
        slewing_d = (state_d == ST_SLEW);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_BYPASS;
            dat_q     <= '0;
            settled_q <= 1'b0;
            slewing_q <= 1'b0;
            limited_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dat_q     <= dat_d;
            settled_q <= settled_d;
            slewing_q <= slewing_d;
            limited_q <= limited_d;
        end
    end

    assign dat_o     = dat_q;
    assign settled_o = settled_q;
    assign slewing_o = slewing_q;
    assign limited_o = limited_q;

endmodule

// File: tb/tb_red_pitaya_dac_slew.sv
// Bench for red_pitaya_dac_slew: directed scenarios plus randomized traffic against a behavioural model.
module tb_red_pitaya_dac_slew;

    localparam int DW = 14;
    localparam int PW = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic signed [DW-1:0] dat_i;
    logic                 enable_i;
    logic                 hold_i;
    logic        [DW-1:0] step_i;
    logic        [PW-1:0] prescale_i;
`ifdef DAC_SLEW_CLAMP_EN
    logic signed [DW-1:0] lo_i;
    logic signed [DW-1:0] hi_i;
`endif
    logic signed [DW-1:0] dat_o;
    logic                 settled_o;
    logic                 slewing_o;
    logic                 limited_o;

    always #5 clk_i = ~clk_i;

    red_pitaya_dac_slew #(
        .DW(DW),
        .PW(PW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .dat_i      (dat_i),
        .enable_i   (enable_i),
        .hold_i     (hold_i),
        .step_i     (step_i),
        .prescale_i (prescale_i),
`ifdef DAC_SLEW_CLAMP_EN
        .lo_i       (lo_i),
        .hi_i       (hi_i),
`endif
        .dat_o      (dat_o),
        .settled_o  (settled_o),
        .slewing_o  (slewing_o),
        .limited_o  (limited_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: output value, active (limiting enabled) flag, slewing flag, sticky flag, tick count
    int m_dat, m_cnt;
    bit m_act, m_slw, m_lim, m_set;

    task automatic check(input string tag, input integer act, input integer exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int target();
        int t;
        t = int'(dat_i);
`ifdef DAC_SLEW_CLAMP_EN
        if (int'(lo_i) > int'(hi_i)) t = int'(lo_i);
        else if (t < int'(lo_i))     t = int'(lo_i);
        else if (t > int'(hi_i))     t = int'(hi_i);
`endif
        return t;
    endfunction

    task automatic model_step();
        int t, d, ad;
        bit tick;
        t = target();
        if (rst_i) begin
            m_dat = 0; m_cnt = 0; m_act = 0; m_slw = 0; m_lim = 0; m_set = 0;
            return;
        end
        if (!enable_i) begin
            m_dat = t; m_act = 0; m_slw = 0; m_lim = 0; m_cnt = 0;
        end else if (!m_act) begin
            m_act = 1; m_cnt = 0;
        end else begin
            tick = !hold_i && (m_cnt >= int'(prescale_i));
            if (!hold_i) m_cnt = tick ? 0 : m_cnt + 1;
            if (tick) begin
                d  = t - m_dat;
                ad = (d < 0) ? -d : d;
                if (ad <= int'(step_i)) begin
                    m_dat = t; m_slw = 0;
                end else begin
                    m_dat = m_dat + ((d > 0) ? int'(step_i) : -int'(step_i));
                    m_lim = 1; m_slw = 1;
                end
            end
        end
        m_set = (m_dat == t);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        model_step();
        #1;
        check("dat_o", int'(dat_o), m_dat);
        check("settled_o", settled_o, m_set);
        check("slewing_o", slewing_o, m_slw);
        check("limited_o", limited_o, m_lim);
    endtask

    initial begin
        int exp2[4];
        int held;
        exp2 = '{1000, 2000, 3000, 3500};
        rst_i = 1'b1; enable_i = 1'b0; hold_i = 1'b0; dat_i = '0;
        step_i = '0; prescale_i = '0;
`ifdef DAC_SLEW_CLAMP_EN
        lo_i = -14'sd8192; hi_i = 14'sd8191;
`endif
        cyc(); cyc();
        check("reset_dat", int'(dat_o), 0);
        check("reset_settled", settled_o, 0);
        rst_i = 1'b0;

        // Bypass: one register stage
        dat_i = 14'sd100;  cyc(); check("byp_100", int'(dat_o), 100);
        dat_i = 14'sd5000; cyc(); check("byp_5000", int'(dat_o), 5000);
        cyc();
        check("byp_settled", settled_o, 1);
        check("byp_limited", limited_o, 0);

        // Slew every clock, step 1000
        dat_i = '0; cyc();
        enable_i = 1'b1; prescale_i = 16'd0; step_i = 14'd1000; cyc();
        dat_i = 14'sd3500;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("slew_seq", int'(dat_o), exp2[i]);
            check("slew_flag", slewing_o, (i < 3) ? 1 : 0);
        end
        check("slew_settled", settled_o, 1);
        cyc();
        check("limited_sticky", limited_o, 1);

        // Prescaled negative slew
        enable_i = 1'b0; dat_i = '0; cyc();
        enable_i = 1'b1; prescale_i = 16'd3; step_i = 14'd10; cyc();
        dat_i = -14'sd25;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 4)  check("ps_tick1", int'(dat_o), -10);
            if (k == 8)  check("ps_tick2", int'(dat_o), -20);
            if (k == 12) check("ps_tick3", int'(dat_o), -25);
        end

        // Hold mid-slew, then disable mid-slew
        step_i = 14'd100; dat_i = 14'sd2000;
        repeat (6) cyc();
        hold_i = 1'b1;
        held = int'(dat_o);
        repeat (20) cyc();
        check("hold_frozen", int'(dat_o), held);
        hold_i = 1'b0;
        repeat (10) cyc();
        check("resume_slewing", slewing_o, 1);
        enable_i = 1'b0; cyc();
        check("dis_dat", int'(dat_o), 2000);
        check("dis_limited", limited_o, 0);

        // Full-scale single tick, then zero step
        dat_i = -14'sd8192; cyc();
        enable_i = 1'b1; prescale_i = 16'd0; step_i = 14'd16383; cyc();
        dat_i = 14'sd8191; cyc();
        check("ext_jump", int'(dat_o), 8191);
        check("ext_nolimit", limited_o, 0);
        step_i = '0; dat_i = '0;
        repeat (30) cyc();
        check("zero_step_dat", int'(dat_o), 8191);
        check("zero_step_slew", slewing_o, 1);

`ifdef DAC_SLEW_CLAMP_EN
        enable_i = 1'b0; lo_i = -14'sd100; hi_i = 14'sd200;
        dat_i = 14'sd1000; cyc(); check("clamp_hi", int'(dat_o), 200);
        dat_i = -14'sd500; cyc(); check("clamp_lo", int'(dat_o), -100);
        lo_i = 14'sd50; hi_i = 14'sd10; cyc(); check("clamp_inv", int'(dat_o), 50);
        lo_i = -14'sd8192; hi_i = 14'sd8191;
`endif

        // Reset mid-slew
        enable_i = 1'b0; dat_i = '0; cyc();
        enable_i = 1'b1; prescale_i = 16'd2; step_i = 14'd5; dat_i = 14'sd3000;
        repeat (8) cyc();
        rst_i = 1'b1; cyc();
        check("rst_mid_dat", int'(dat_o), 0);
        check("rst_mid_slew", slewing_o, 0);
        rst_i = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(99) < 2)  enable_i = ~enable_i;
            hold_i = ($urandom_range(9) == 0);
            if ($urandom_range(99) < 5)  dat_i = 14'($urandom());
            if ($urandom_range(99) < 2)
                step_i = ($urandom_range(3) == 0) ? 14'($urandom()) : 14'($urandom_range(0, 300));
            if ($urandom_range(99) < 2)  prescale_i = 16'($urandom_range(0, 5));
            rst_i = ($urandom_range(999) < 3);
`ifdef DAC_SLEW_CLAMP_EN
            if ($urandom_range(99) < 1) begin
                lo_i = 14'($urandom());
                hi_i = 14'($urandom());
            end
`endif
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
